counter_64: RTL and testbench



---
 rtl/counter_64_if.sv | 34 +++
 rtl/counter_64.sv | 64 ++++++
 tb/tb_counter_64.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_64_if.sv
// ---------------------------------------------------------------------------
// counter_64_if
// Bundles the counter's enable input and its status outputs so the harness
// can hand a single port to the counter.
//   increment : count enable, sampled on the rising clock edge
//   count     : registered running count (WIDTH bits)
//   carry     : one-cycle pulse in the cycle following a wrap
//   overflow  : sticky wrap flag, cleared only by reset
// Modports:
//   master : harness side (drives increment, observes status)
//   slave  : counter side (observes increment, drives status)
// ---------------------------------------------------------------------------
interface counter_64_if #(
    parameter int unsigned WIDTH = 64
);
    logic             increment;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             overflow;

    modport master (
        output increment,
        input  count,
        input  carry,
        input  overflow
    );

    modport slave (
        input  increment,
        output count,
        output carry,
        output overflow
    );
endinterface

// File: rtl/counter_64.sv
// ---------------------------------------------------------------------------
// counter_64
// Free-running event/cycle counter used to timestamp accelerator start/done.
// Adds STEP to the count on every enabled clock edge, wrapping modulo
// 2^WIDTH, and reports wraps through a one-cycle carry pulse and a sticky
// overflow flag so long runs cannot alias silently.
// Parameters:
//   WIDTH : counter width in bits, 2..64
//   STEP  : amount added per enabled cycle, unsigned, < 2^WIDTH
// Ports:
//   clk    : single clock, all state changes on its rising edge
//   rst    : asynchronous active-low reset
//   cnt_if : counter_64_if slave modport (increment in; count/carry/overflow out)
// ---------------------------------------------------------------------------
module counter_64 #(
    parameter int unsigned      WIDTH = 64,
    parameter logic [WIDTH-1:0] STEP  = WIDTH'(1)
) (
    input  logic        clk,
    input  logic        rst,
    counter_64_if.slave cnt_if
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             carry_q;
    logic             carry_d;
    logic             overflow_q;
    logic             overflow_d;

    // One extra bit on the adder: its MSB is the wrap indication.
    logic [WIDTH:0]   sum;

    assign sum = {1'b0, count_q} + {1'b0, STEP};

    always_comb begin
        count_d    = count_q;
        carry_d    = 1'b0;
        overflow_d = overflow_q;
        if (cnt_if.increment) begin
            count_d    = sum[WIDTH-1:0];
            carry_d    = sum[WIDTH];
            overflow_d = overflow_q | sum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs come straight from flops; no input-to-output combinational path.
    assign cnt_if.count    = count_q;
    assign cnt_if.carry    = carry_q;
    assign cnt_if.overflow = overflow_q;

endmodule

// File: tb/tb_counter_64.sv
// ---------------------------------------------------------------------------
// tb_counter_64
// Three counter instances share clock and reset:
//   inst 0 : WIDTH=64, STEP=1
//   inst 1 : WIDTH=4,  STEP=1
//   inst 2 : WIDTH=4,  STEP=3
// Each driven cycle updates a reference model per instance and pushes the
// expected outputs to a scoreboard queue; after the edge the queue is
// drained and compared with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_counter_64;

    logic clk;
    logic rst;

    counter_64_if #(.WIDTH(64)) if_a ();
    counter_64_if #(.WIDTH(4))  if_b ();
    counter_64_if #(.WIDTH(4))  if_c ();

    counter_64 #(.WIDTH(64), .STEP(64'd1)) u_a (.clk(clk), .rst(rst), .cnt_if(if_a));
    counter_64 #(.WIDTH(4),  .STEP(4'd1))  u_b (.clk(clk), .rst(rst), .cnt_if(if_b));
    counter_64 #(.WIDTH(4),  .STEP(4'd3))  u_c (.clk(clk), .rst(rst), .cnt_if(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [63:0] cnt;
        logic        cy;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    logic [63:0] m_cnt  [3];
    logic        m_cy   [3];
    logic        m_ov   [3];
    logic [63:0] m_mask [3];
    logic [63:0] m_step [3];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [63:0] obs_cnt(input int i);
        case (i)
            0:       return if_a.count;
            1:       return {60'd0, if_b.count};
            default: return {60'd0, if_c.count};
        endcase
    endfunction

    function automatic logic obs_cy(input int i);
        case (i)
            0:       return if_a.carry;
            1:       return if_b.carry;
            default: return if_c.carry;
        endcase
    endfunction

    function automatic logic obs_ov(input int i);
        case (i)
            0:       return if_a.overflow;
            1:       return if_b.overflow;
            default: return if_c.overflow;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = '0;
            m_cy[i]  = 1'b0;
            m_ov[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic en);
        logic [64:0] s;
        if (!rst) begin
            m_cnt[i] = '0;
            m_cy[i]  = 1'b0;
            m_ov[i]  = 1'b0;
        end else if (en) begin
            s        = {1'b0, m_cnt[i]} + {1'b0, m_step[i]};
            m_cy[i]  = (s > {1'b0, m_mask[i]});
            m_cnt[i] = s[63:0] & m_mask[i];
            m_ov[i]  = m_ov[i] | m_cy[i];
        end else begin
            m_cy[i] = 1'b0;
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("i%0d_count", e.inst), obs_cnt(e.inst), e.cnt);
            chk($sformatf("i%0d_carry", e.inst), {63'd0, obs_cy(e.inst)}, {63'd0, e.cy});
            chk($sformatf("i%0d_overflow", e.inst), {63'd0, obs_ov(e.inst)}, {63'd0, e.ov});
        end
    endtask

    // Called one time unit after a rising edge; leaves the same phase.
    task automatic drive(input logic ia, input logic ib, input logic ic);
        logic en [3];
        en[0] = ia; en[1] = ib; en[2] = ic;
        if_a.increment = ia;
        if_b.increment = ib;
        if_c.increment = ic;
        for (int i = 0; i < 3; i++) begin
            model_step(i, en[i]);
            sb.push_back('{inst: i, cnt: m_cnt[i], cy: m_cy[i], ov: m_ov[i]});
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic run(input int n, input logic ia, input logic ib, input logic ic);
        for (int k = 0; k < n; k++) drive(ia, ib, ic);
    endtask

    // Pulls reset between edges, checks outputs cleared before any edge,
    // holds it for `hold` cycles with increment asserted, then releases.
    task automatic do_reset(input int hold);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_i%0d_count", i), obs_cnt(i), 64'd0);
            chk($sformatf("rst_i%0d_carry", i), {63'd0, obs_cy(i)}, 64'd0);
            chk($sformatf("rst_i%0d_overflow", i), {63'd0, obs_ov(i)}, 64'd0);
        end
        @(posedge clk);
        #1;
        run(hold, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
    endtask

    logic [63:0] t_start;
    logic [63:0] t_end;
    logic        gp [7];

    initial begin
        m_mask[0] = 64'hFFFF_FFFF_FFFF_FFFF; m_step[0] = 64'd1;
        m_mask[1] = 64'h0000_0000_0000_000F; m_step[1] = 64'd1;
        m_mask[2] = 64'h0000_0000_0000_000F; m_step[2] = 64'd3;
        model_reset();
        if_a.increment = 1'b1;
        if_b.increment = 1'b1;
        if_c.increment = 1'b1;
        rst = 1'b0;
        #1;
        chk("init_count", if_a.count, 64'd0);
        chk("init_overflow", {63'd0, if_a.overflow}, 64'd0);

        // Reset held 3 cycles with increment high, then free run for 10.
        @(posedge clk);
        #1;
        run(3, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        run(10, 1'b1, 1'b1, 1'b1);
        chk("free_count", if_a.count, 64'd10);
        chk("free_carry", {63'd0, if_a.carry}, 64'd0);
        chk("free_overflow", {63'd0, if_a.overflow}, 64'd0);

        // Gated counting 1,0,1,1,0,0,1.
        do_reset(1);
        gp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) drive(gp[k], gp[k], gp[k]);
        chk("gated_count", if_a.count, 64'd4);

        // Async reset mid-run at count 25, then 3 enabled edges.
        do_reset(1);
        run(25, 1'b1, 1'b0, 1'b0);
        chk("pre_async_count", if_a.count, 64'd25);
        do_reset(0);
        run(3, 1'b1, 1'b1, 1'b1);
        chk("post_async_count", if_a.count, 64'd3);

        // Wrap behaviour on the 4-bit instances.
        do_reset(1);
        for (int k = 1; k <= 17; k++) begin
            drive(1'b1, 1'b1, (k <= 6));
            if (k == 6) begin
                chk("s3_count", {60'd0, if_c.count}, 64'd2);
                chk("s3_carry", {63'd0, if_c.carry}, 64'd1);
                chk("s3_overflow", {63'd0, if_c.overflow}, 64'd1);
            end
            if (k == 15) begin
                chk("w15_count", {60'd0, if_b.count}, 64'd15);
                chk("w15_carry", {63'd0, if_b.carry}, 64'd0);
            end
            if (k == 16) begin
                chk("w16_count", {60'd0, if_b.count}, 64'd0);
                chk("w16_carry", {63'd0, if_b.carry}, 64'd1);
                chk("w16_overflow", {63'd0, if_b.overflow}, 64'd1);
            end
            if (k == 17) begin
                chk("w17_count", {60'd0, if_b.count}, 64'd1);
                chk("w17_carry", {63'd0, if_b.carry}, 64'd0);
                chk("w17_overflow", {63'd0, if_b.overflow}, 64'd1);
            end
        end

        // Elapsed measurement across 1000 enabled edges.
        do_reset(1);
        run(7, 1'b1, 1'b1, 1'b1);
        t_start = if_a.count;
        chk("elapsed_start", t_start, 64'd7);
        run(1000, 1'b1, 1'b1, 1'b1);
        t_end = if_a.count;
        chk("elapsed_diff", t_end - t_start, 64'd1000);

        // Random per-instance gating against the model.
        for (int k = 0; k < 200; k++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
